// File: rtl/chess_turn_clock.sv
// Turn sequencer and per-player countdown clock for the timed chess game.
// Tracks whose move it is, each side's remaining seconds, and flags a loss on time.
// Every output is a flop; the next-state logic is one combinational block.

module chess_turn_clock #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TIME_SEC = 600,
  parameter int INC_SEC  = 0,
  parameter int TIME_W   = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic              move_done,
  output logic [1:0]        state,
  output logic [TIME_W-1:0] white_time,
  output logic [TIME_W-1:0] black_time,
  output logic              sec_tick,
  output logic              timeout,
  output logic              winner
);

  localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(CLK_HZ - 1);
  localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(TIME_SEC);
  localparam logic [TIME_W-1:0] TIME_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WHITE = 2'b01,
    BLACK = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic [TIME_W-1:0] white_d, black_d;
  logic              tick_d, timeout_d, winner_d;

  logic              tick_now;
  logic [TIME_W-1:0] active_time;
  logic [TIME_W-1:0] dec_time;
  logic [31:0]       inc_sum;
  logic [TIME_W-1:0] moved_time;
  logic [TIME_W-1:0] active_next;

  assign state = state_q;

  // Next-state logic: abort overrides everything, a timeout beats a coincident move,
  // and a move applies the increment on top of any same-cycle decrement.
  always_comb begin
    state_d     = state_q;
    ps_d        = ps_q;
    white_d     = white_time;
    black_d     = black_time;
    tick_d      = 1'b0;
    timeout_d   = timeout;
    winner_d    = winner;
    active_next = '0;

    active_time = (state_q == BLACK) ? black_time : white_time;
    tick_now    = ((state_q == WHITE) || (state_q == BLACK)) && !pause && (ps_q == PS_LAST);
    dec_time    = (tick_now && (active_time != '0)) ? active_time - 1'b1 : active_time;
    inc_sum     = 32'(dec_time) + 32'(INC_SEC);
    moved_time  = (inc_sum > 32'(TIME_MAX)) ? TIME_MAX : TIME_W'(inc_sum);

    if (abort) begin
      state_d   = IDLE;
      ps_d      = '0;
      white_d   = TIME_INIT;
      black_d   = TIME_INIT;
      timeout_d = 1'b0;
      winner_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, OVER: begin
          ps_d = '0;
          if (start) begin
            state_d   = WHITE;
            white_d   = TIME_INIT;
            black_d   = TIME_INIT;
            timeout_d = 1'b0;
            winner_d  = 1'b0;
          end
        end
        WHITE, BLACK: begin
          if (!pause) begin
            tick_d = tick_now;
            ps_d   = tick_now ? '0 : ps_q + 1'b1;
            if (tick_now && (dec_time == '0)) begin
              active_next = '0;
              state_d     = OVER;
              timeout_d   = 1'b1;
              winner_d    = (state_q == BLACK);
            end else if (move_done) begin
              active_next = moved_time;
              ps_d        = '0;
              state_d     = (state_q == WHITE) ? BLACK : WHITE;
            end else begin
              active_next = dec_time;
            end
            if (state_q == WHITE) begin
              white_d = active_next;
            end else begin
              black_d = active_next;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, prescaler and all outputs register here; reset returns to a fresh idle board.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ps_q       <= '0;
      white_time <= TIME_INIT;
      black_time <= TIME_INIT;
      sec_tick   <= 1'b0;
      timeout    <= 1'b0;
      winner     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      white_time <= white_d;
      black_time <= black_d;
      sec_tick   <= tick_d;
      timeout    <= timeout_d;
      winner     <= winner_d;
    end
  end

endmodule
